// File: rtl/fpu_short_issuer.sv
// Initiator for the short-latency FPU port: accepts one op, pulses fpu_en, captures result for writeback.
// Latency: accept -> wb_valid is FPU latency + 1 cycles (minimum 2); one op in flight.
// Backpressure: req_ready drops while an op is pending; wb_valid holds until wb_ready, and a new op may be accepted in the release cycle.
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   req_valid/req_ready + req_*   op from execute (x, y, funct5, rm, rd tag)
//   fpu_en, fpu_x/y/funct5/rm     one-cycle start pulse and registered operands to the FPU
//   fpu_res, fpu_valid            FPU result and strobe
//   wb_valid/wb_ready, wb_data/rd buffered result to writeback
//   busy, timeout_err             op pending, sticky FPU timeout flag
// Optional feature: define FPU_ISSUE_TIMEOUT_EN to bound the wait for fpu_valid to TIMEOUT_CYCLES.
module fpu_short_issuer #(
  parameter int unsigned RD_W           = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x,
  input  logic [31:0]     req_y,
  input  logic [4:0]      req_funct5,
  input  logic [2:0]      req_rm,
  input  logic [RD_W-1:0] req_rd,
  output logic            fpu_en,
  output logic [31:0]     fpu_x,
  output logic [31:0]     fpu_y,
  output logic [4:0]      fpu_funct5,
  output logic [2:0]      fpu_rm,
  input  logic [31:0]     fpu_res,
  input  logic            fpu_valid,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            busy,
  output logic            timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("fpu_short_issuer: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [31:0]       x_q, x_d, y_q, y_d;
  logic [4:0]        f5_q, f5_d;
  logic [2:0]        rm_q, rm_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              en_q, en_d;
  logic              wbv_q, wbv_d;
  logic [31:0]       wbd_q, wbd_d;
  logic [RD_W-1:0]   wbrd_q, wbrd_d;
  logic              accept;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;
`endif

  // Ready in RESP depends on wb_ready so the release cycle can take the next op (no bubble).
  assign req_ready = (state_q == IDLE) | ((state_q == RESP) & wb_ready);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    f5_d    = f5_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    en_d    = 1'b0;
    wbv_d   = wbv_q;
    wbd_d   = wbd_q;
    wbrd_d  = wbrd_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        // fpu_valid is honoured even in the fpu_en cycle and takes priority over the timeout.
        if (fpu_valid) begin
          wbd_d   = fpu_res;
          wbrd_d  = rd_q;
          wbv_d   = 1'b1;
          state_d = RESP;
        end
`ifdef FPU_ISSUE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          wbd_d   = 32'h7FC0_0000;  // canonical quiet NaN
          wbrd_d  = rd_q;
          wbv_d   = 1'b1;
          terr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (wb_ready) begin
          wbv_d   = 1'b0;
          state_d = accept ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      x_d  = req_x;
      y_d  = req_y;
      f5_d = req_funct5;
      rm_d = req_rm;
      rd_d = req_rd;
      en_d = 1'b1;
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      f5_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      en_q    <= 1'b0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
      wbrd_q  <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f5_q    <= f5_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbrd_q  <= wbrd_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign fpu_en     = en_q;
  assign fpu_x      = x_q;
  assign fpu_y      = y_q;
  assign fpu_funct5 = f5_q;
  assign fpu_rm     = rm_q;
  assign wb_valid   = wbv_q;
  assign wb_data    = wbd_q;
  assign wb_rd      = wbrd_q;
  assign busy       = (state_q != IDLE);
`ifdef FPU_ISSUE_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_short_issuer.sv
// Directed + randomized bench for fpu_short_issuer with a transaction-level model:
// ops are issued, a bench FPU answers after a chosen latency, and results are checked from an expected queue.
// Writeback stalls and stray fpu_valid strobes are injected; timeout cases run when FPU_ISSUE_TIMEOUT_EN is defined.
module tb_fpu_short_issuer;
  localparam int RD_W = 5;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk, rstn;
  logic req_valid, req_ready;
  logic [31:0] req_x, req_y;
  logic [4:0] req_funct5;
  logic [2:0] req_rm;
  logic [RD_W-1:0] req_rd;
  logic fpu_en;
  logic [31:0] fpu_x, fpu_y;
  logic [4:0] fpu_funct5;
  logic [2:0] fpu_rm;
  logic [31:0] fpu_res;
  logic fpu_valid;
  logic wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [RD_W-1:0] wb_rd;
  logic busy, timeout_err;

  fpu_short_issuer #(.RD_W(RD_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_funct5(req_funct5), .req_rm(req_rm), .req_rd(req_rd),
    .fpu_en(fpu_en), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_funct5(fpu_funct5), .fpu_rm(fpu_rm),
    .fpu_res(fpu_res), .fpu_valid(fpu_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, res;
    logic [4:0] f5;
    logic [2:0] rm;
    logic [RD_W-1:0] rd;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic [RD_W-1:0] rd;
  } wb_t;

  wb_t  exp_q[$];
  logic exp_terr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.x   = $urandom;
    o.y   = $urandom;
    o.res = $urandom;
    o.f5  = 5'($urandom);
    o.rm  = 3'($urandom);
    o.rd  = RD_W'($urandom);
    return o;
  endfunction

  // Writeback-side expectation for the current cycle (call after negedge).
  task automatic expect_resp_now();
    if (exp_q.size() > 0) begin
      chk("wb_valid_hi", 32'(wb_valid), 32'd1);
      chk("wb_data", wb_data, exp_q[0].data);
      chk("wb_rd", 32'(wb_rd), 32'(exp_q[0].rd));
    end else begin
      chk("wb_valid_lo", 32'(wb_valid), 32'd0);
    end
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
  endtask

  // Offer op in the current cycle; returns in the fpu_en cycle. If a result is pending, wb_ready must already be 1.
  task automatic issue(input op_t op);
    req_valid  = 1'b1;
    req_x      = op.x;
    req_y      = op.y;
    req_funct5 = op.f5;
    req_rm     = op.rm;
    req_rd     = op.rd;
    @(negedge clk);
    chk("req_ready_accept", 32'(req_ready), 32'd1);
    expect_resp_now();
    step();
    if (exp_q.size() > 0) begin
      wb_t gone;
      gone = exp_q.pop_front();
    end
    req_valid  = 1'b0;
    wb_ready   = 1'b0;
    req_x      = $urandom;
    req_y      = $urandom;
    req_funct5 = 5'($urandom);
    req_rm     = 3'($urandom);
    req_rd     = RD_W'($urandom);
  endtask

  // Bench FPU answers in cycle 'lat' after accept (cycle 1 = fpu_en cycle) unless respond=0;
  // then writeback is stalled 'stall' cycles with stray strobes. Returns in the release cycle with wb_ready=1.
  task automatic wait_result(input op_t op, input int lat, input int stall, input bit respond);
    for (int c = 1; c <= lat; c++) begin
      fpu_valid = respond && (c == lat);
      fpu_res   = (c == lat) ? op.res : $urandom;
      @(negedge clk);
      chk("fpu_en", 32'(fpu_en), 32'(c == 1));
      chk("fpu_x", fpu_x, op.x);
      chk("fpu_y", fpu_y, op.y);
      chk("fpu_funct5", 32'(fpu_funct5), 32'(op.f5));
      chk("fpu_rm", 32'(fpu_rm), 32'(op.rm));
      chk("busy_wait", 32'(busy), 32'd1);
      chk("req_ready_wait", 32'(req_ready), 32'd0);
      chk("wb_valid_wait", 32'(wb_valid), 32'd0);
      step();
    end
    fpu_valid = 1'b0;
    if (respond) begin
      exp_q.push_back('{data: op.res, rd: op.rd});
    end else begin
      exp_q.push_back('{data: 32'h7FC0_0000, rd: op.rd});
      exp_terr = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      wb_ready  = 1'b0;
      fpu_valid = 1'($urandom);
      fpu_res   = $urandom;
      @(negedge clk);
      expect_resp_now();
      chk("req_ready_stall", 32'(req_ready), 32'd0);
      chk("fpu_en_stall", 32'(fpu_en), 32'd0);
      step();
    end
    fpu_valid = 1'b0;
    wb_ready  = 1'b1;
  endtask

  // Release the pending result and go idle; a stray strobe in IDLE must do nothing.
  task automatic release_idle();
    @(negedge clk);
    expect_resp_now();
    chk("req_ready_release", 32'(req_ready), 32'd1);
    step();
    begin
      wb_t gone;
      gone = exp_q.pop_front();
    end
    wb_ready  = 1'b0;
    fpu_valid = 1'b1;
    fpu_res   = $urandom;
    @(negedge clk);
    chk("wb_valid_idle", 32'(wb_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    fpu_valid = 1'b0;
    @(negedge clk);
    chk("wb_valid_after_stray", 32'(wb_valid), 32'd0);
    chk("busy_after_stray", 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    op_t op, op2;
    rstn = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_funct5 = '0; req_rm = '0; req_rd = '0;
    fpu_res = '0; fpu_valid = 1'b0; wb_ready = 1'b0;

    // Reset held 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_fpu_en", 32'(fpu_en), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_fpu_x", fpu_x, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rstn = 1'b1;
    step();

    // Single op 1.0 + 2.0, FPU latency 3, writeback stalled 4 cycles.
    op = '{x: 32'h3F80_0000, y: 32'h4000_0000, res: 32'h4040_0000, f5: 5'd0, rm: 3'd0, rd: 5'd5};
    issue(op);
    wait_result(op, 3, 4, 1'b1);
    // Back-to-back second op (rd=7) in the release cycle, FPU latency 1.
    op2 = rand_op();
    op2.rd = 5'd7;
    issue(op2);
    wait_result(op2, 1, 0, 1'b1);
    release_idle();

    // Randomized ops: latency 1..6, stall 0..3, random back-to-back chaining.
    op = rand_op();
    issue(op);
    for (int n = 0; n < 30; n++) begin
      wait_result(op, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b1);
      op = rand_op();
      if ($urandom_range(0, 1) == 0) release_idle();
      issue(op);
    end
    wait_result(op, 2, 1, 1'b1);
    release_idle();

`ifdef FPU_ISSUE_TIMEOUT_EN
    // fpu_valid on the limit cycle wins: normal capture, no error.
    op = rand_op();
    issue(op);
    wait_result(op, TO + 1, 0, 1'b1);
    release_idle();
    // FPU never responds: forced NaN completion, sticky error.
    op = rand_op();
    issue(op);
    wait_result(op, TO + 1, 2, 1'b0);
    release_idle();
    op = rand_op();
    issue(op);
    wait_result(op, 2, 1, 1'b1);
    release_idle();
    @(negedge clk);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    step();
`endif

    // Reset mid-WAIT abandons the op; a late fpu_valid is ignored.
    op = rand_op();
    issue(op);
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    exp_terr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fpu_valid = 1'b1;
      fpu_res   = $urandom;
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_mid_fpu_en", 32'(fpu_en), 32'd0);
      chk("rst_mid_timeout_err", 32'(timeout_err), 32'd0);
      step();
    end
    fpu_valid = 1'b0;

    // Still functional after reset.
    op = rand_op();
    issue(op);
    wait_result(op, 1, 0, 1'b1);
    release_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
